// File: rtl/mult_seq_ovf.sv
// Multicycle radix-2 Booth signed multiplier with exact overflow detection.
// Optional saturation of the result on overflow: define MULT_SAT_EN.
module mult_seq_ovf #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH:0]     acc;
    logic [WIDTH-1:0]   q;
    logic               q_m1;

    logic               accept;
    logic               last_step;
    logic [WIDTH:0]     mcand_ext;
    logic [WIDTH:0]     acc_sum;
    logic [WIDTH:0]     acc_sh;
    logic [WIDTH-1:0]   q_sh;
    logic               q_m1_sh;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH:0]     prod_hi;
    logic               ovf_nxt;
    logic [WIDTH-1:0]   res_nxt;

    assign ready     = (state == S_IDLE) || (state == S_DONE);
    assign busy      = (state == S_RUN);
    assign accept    = ready && start;
    assign last_step = (state == S_RUN) && (count == CNT_W'(WIDTH - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last_step) state_nxt = S_DONE;
            S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // One Booth step; the W+1-bit accumulator keeps -2^(W-1) from wrapping.
    always_comb begin
        mcand_ext = {mcand[WIDTH-1], mcand};
        acc_sum   = acc;
        case ({q[0], q_m1})
            2'b01:   acc_sum = acc + mcand_ext;
            2'b10:   acc_sum = acc - mcand_ext;
            default: acc_sum = acc;
        endcase
        {acc_sh, q_sh, q_m1_sh} = {acc_sum[WIDTH], acc_sum, q};
        product = {acc_sh[WIDTH-1:0], q_sh};
        prod_hi = product[2*WIDTH-1:WIDTH-1];
        ovf_nxt = !((&prod_hi) || !(|prod_hi));
`ifdef MULT_SAT_EN
        if (ovf_nxt)
            res_nxt = product[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
        else
            res_nxt = product[WIDTH-1:0];
`else
        res_nxt = product[WIDTH-1:0];
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            mcand    <= '0;
            acc      <= '0;
            q        <= '0;
            q_m1     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            done <= last_step;
            if (accept) begin
                mcand <= multiplicand;
                acc   <= '0;
                q     <= multiplier;
                q_m1  <= 1'b0;
                count <= '0;
            end else if (state == S_RUN) begin
                acc   <= acc_sh;
                q     <= q_sh;
                q_m1  <= q_m1_sh;
                count <= count + CNT_W'(1);
            end
            if (last_step) begin
                result   <= res_nxt;
                overflow <= ovf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_mult_seq_ovf.sv
// Directed self-checking bench for mult_seq_ovf at WIDTH=32 and WIDTH=8.
module tb_mult_seq_ovf;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start32 = 1'b0, start8 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        ready32, busy32, done32, ovf32;
    logic        ready8, busy8, done8, ovf8;
    logic [31:0] res32;
    logic [7:0]  res8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    mult_seq_ovf #(.WIDTH(32)) dut32 (
        .clock(clock), .reset_n(reset_n), .start(start32),
        .multiplicand(a32), .multiplier(b32),
        .ready(ready32), .busy(busy32), .done(done32),
        .result(res32), .overflow(ovf32)
    );

    mult_seq_ovf #(.WIDTH(8)) dut8 (
        .clock(clock), .reset_n(reset_n), .start(start8),
        .multiplicand(a8), .multiplier(b8),
        .ready(ready8), .busy(busy8), .done(done8),
        .result(res8), .overflow(ovf8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Accept on the next edge, then count edges until done (bounded).
    task automatic run32(input logic [31:0] a, input logic [31:0] b, output int cycles);
        @(negedge clock);
        a32 = a; b32 = b; start32 = 1'b1;
        @(posedge clock); #1;
        start32 = 1'b0;
        cycles = 0;
        while (!done32 && cycles < 100) begin
            @(posedge clock); #1;
            cycles++;
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, output int cycles);
        @(negedge clock);
        a8 = a; b8 = b; start8 = 1'b1;
        @(posedge clock); #1;
        start8 = 1'b0;
        cycles = 0;
        while (!done8 && cycles < 100) begin
            @(posedge clock); #1;
            cycles++;
        end
    endtask

    initial begin
        int cyc;
        int seen;

        #12;
        check("rst_ready", ready32, 1);
        check("rst_busy", busy32, 0);
        check("rst_done", done32, 0);
        check("rst_result", res32, 0);
        check("rst_ovf", ovf32, 0);
        @(negedge clock);
        reset_n = 1'b1;

        run32(32'd3, 32'd4, cyc);
        check("lat_3x4", cyc, 32);
        check("res_3x4", res32, 32'h0000000C);
        check("ovf_3x4", ovf32, 0);
        check("ready_in_done", ready32, 1);
        check("busy_in_done", busy32, 0);
        @(posedge clock); #1;
        check("done_pulse_drop", done32, 0);
        check("hold_result", res32, 32'h0000000C);
        check("ready_idle", ready32, 1);

        run32(32'h7FFFFFFF, 32'd2, cyc);
`ifdef MULT_SAT_EN
        check("res_max_x2", res32, 32'h7FFFFFFF);
`else
        check("res_max_x2", res32, 32'hFFFFFFFE);
`endif
        check("ovf_max_x2", ovf32, 1);

        run32(32'h80000000, 32'hFFFFFFFF, cyc);
`ifdef MULT_SAT_EN
        check("res_min_xm1", res32, 32'h7FFFFFFF);
`else
        check("res_min_xm1", res32, 32'h80000000);
`endif
        check("ovf_min_xm1", ovf32, 1);

        run32(32'h00010000, 32'h00008000, cyc);
`ifdef MULT_SAT_EN
        check("res_2p31", res32, 32'h7FFFFFFF);
`else
        check("res_2p31", res32, 32'h80000000);
`endif
        check("ovf_2p31", ovf32, 1);

        run32(32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
        check("res_m1xm1", res32, 32'h00000001);
        check("ovf_m1xm1", ovf32, 0);

        run32(32'h00000000, 32'h80000000, cyc);
        check("res_0xmin", res32, 32'h00000000);
        check("ovf_0xmin", ovf32, 0);

        run32(32'h80000000, 32'h00000001, cyc);
        check("res_minx1", res32, 32'h80000000);
        check("ovf_minx1", ovf32, 0);

        run32(32'hFFFFFFFD, 32'd5, cyc);
        check("res_m3x5", res32, 32'hFFFFFFF1);
        check("ovf_m3x5", ovf32, 0);

        // start pulsed mid-run with different operands must be ignored
        @(negedge clock);
        a32 = 32'd5; b32 = 32'd7; start32 = 1'b1;
        @(posedge clock); #1;
        start32 = 1'b0;
        cyc = 0;
        while (!done32 && cyc < 100) begin
            if (cyc == 5) begin
                a32 = 32'd9; b32 = 32'd9; start32 = 1'b1;
            end
            if (cyc == 6) start32 = 1'b0;
            @(posedge clock); #1;
            cyc++;
        end
        check("lat_ignore", cyc, 32);
        check("res_ignore", res32, 32'd35);

        // reset mid-run aborts: no done, outputs cleared
        @(negedge clock);
        a32 = 32'd2; b32 = 32'd2; start32 = 1'b1;
        @(posedge clock); #1;
        start32 = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("abort_ready", ready32, 1);
        check("abort_busy", busy32, 0);
        check("abort_result", res32, 0);
        check("abort_done", done32, 0);
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done32) seen++;
        end
        check("abort_no_done", seen, 0);

        // back-to-back: start held in DONE goes straight to RUN
        run32(32'd6, 32'd7, cyc);
        check("res_6x7", res32, 32'd42);
        a32 = 32'hFFFFFFFE; b32 = 32'd3; start32 = 1'b1;
        @(posedge clock); #1;
        start32 = 1'b0;
        check("b2b_busy", busy32, 1);
        cyc = 0;
        while (!done32 && cyc < 100) begin
            @(posedge clock); #1;
            cyc++;
            if (cyc == 16) check("hold_during_run", res32, 32'd42);
        end
        check("lat_b2b", cyc, 32);
        check("res_b2b", res32, 32'hFFFFFFFA);
        check("ovf_b2b", ovf32, 0);

        // WIDTH=8 instance
        run8(8'h80, 8'h01, cyc);
        check("w8_lat", cyc, 8);
        check("w8_res_minx1", res8, 8'h80);
        check("w8_ovf_minx1", ovf8, 0);
        run8(8'hF0, 8'h10, cyc);
`ifdef MULT_SAT_EN
        check("w8_res_m16x16", res8, 8'h80);
`else
        check("w8_res_m16x16", res8, 8'h00);
`endif
        check("w8_ovf_m16x16", ovf8, 1);
        run8(8'h7F, 8'h7F, cyc);
`ifdef MULT_SAT_EN
        check("w8_res_maxsq", res8, 8'h7F);
`else
        check("w8_res_maxsq", res8, 8'h01);
`endif
        check("w8_ovf_maxsq", ovf8, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
